// File: rtl/rv32_fetch_pkg.sv
// Shared constants and types for the instruction-fetch stage.
package rv32_fetch_pkg;

    // Canonical RISC-V NOP: addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] PC_STEP          = 32'd4;

    // One prefetch buffer entry: the instruction and the PC it was fetched from.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    // What the fetch-to-decode register does on the next edge.
    typedef enum logic [1:0] {
        DEC_BUBBLE = 2'd0,
        DEC_HOLD   = 2'd1,
        DEC_LOAD   = 2'd2
    } dec_action_e;

    // Instruction fetches are always word aligned; drop the byte offset.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/rv32_f_prefetch_fifo.sv
// Small prefetch FIFO between the imem response channel and decode.
// Head data is visible combinationally; a push into an empty FIFO is only
// visible at the head from the following cycle (no bypass path).
module rv32_f_prefetch_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 64
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic                       i_clear,
    input  logic [WIDTH-1:0]           i_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic [WIDTH-1:0]           o_head
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    logic w_do_push;
    logic w_do_pop;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];

    // A pop is only real when there is data; a push into a full FIFO is only
    // taken when the same-cycle pop frees a slot. Clear overrides both.
    assign w_do_pop  = i_pop && !i_clear && !o_empty;
    assign w_do_push = i_push && !i_clear && (!o_full || w_do_pop);

    // Storage array: written at the tail, no reset needed on the data.
    always_ff @(posedge clk_i) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointer and occupancy bookkeeping; DEPTH is a power of two so the
    // pointers wrap naturally.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/rv32_fetch.sv
// RV32 instruction-fetch stage: owns the fetch PC, issues imem requests
// under a credit scheme that always leaves room in the prefetch FIFO for
// every response, drops responses that were in flight across a redirect,
// and drives the fetch-to-decode pipeline register.
module rv32_fetch
    import rv32_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC        = DEFAULT_RESET_PC,
    parameter int unsigned FIFO_DEPTH      = 2,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        stall_d_i,
    input  logic        flush_d_i,
    input  logic        redirect_i,
    input  logic [31:0] pc_target_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ready_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic [31:0] pc_next_o,
    output logic        valid_o
);

    localparam int unsigned OW = $clog2(MAX_OUTSTANDING+1);
    localparam int unsigned CW = $clog2(FIFO_DEPTH+1);

    // Fetch-side state
    logic [31:0]   r_pc;
    logic [31:0]   r_rsp_pc;
    logic [OW-1:0] r_outstanding;
    logic [OW-1:0] r_discard;

    // Fetch-to-decode register
    logic [31:0]   r_instr_d;
    logic [31:0]   r_pc_d;
    logic [31:0]   r_pc_next_d;
    logic          r_valid_d;

    // Combinational
    logic [31:0]   w_target;
    logic [31:0]   w_credit_used;
    logic          w_req;
    logic          w_accept;
    logic          w_push;
    logic          w_pop;
    logic          w_fifo_full;
    logic          w_fifo_empty;
    logic [CW-1:0] w_fifo_count;
    fetch_entry_t  w_push_entry;
    fetch_entry_t  w_head;
    dec_action_e   w_dec_action;

    assign w_target = align_word(pc_target_i);

    // Requests in flight plus buffered entries may never exceed the FIFO
    // depth, so a response can always be accepted without backpressure.
    assign w_credit_used = 32'(r_outstanding) + 32'(w_fifo_count);

    // Gating with the reset keeps the request low while reset is asserted.
    // Every other term can only relax while a request waits for ready, so the
    // request and its address stay stable until accepted (or redirected).
    assign w_req = rst_n_i
                && !redirect_i
                && (r_discard == '0)
                && (32'(r_outstanding) < MAX_OUTSTANDING)
                && (w_credit_used < FIFO_DEPTH);

    assign w_accept    = w_req && imem_ready_i;
    assign imem_req_o  = w_req;
    assign imem_addr_o = r_pc;

    // A response is kept only if it belongs to the current fetch stream.
    assign w_push       = imem_rvalid_i && !redirect_i && (r_discard == '0);
    assign w_push_entry = '{pc: r_rsp_pc, instr: imem_rdata_i};

    // Decode register control: flush > stall > load. A redirect empties the
    // FIFO this cycle, so without a flush the register still takes a bubble.
    always_comb begin
        w_dec_action = DEC_BUBBLE;
        if (flush_d_i) begin
            w_dec_action = DEC_BUBBLE;
        end else if (stall_d_i) begin
            w_dec_action = DEC_HOLD;
        end else if (redirect_i) begin
            w_dec_action = DEC_BUBBLE;
        end else if (!w_fifo_empty) begin
            w_dec_action = DEC_LOAD;
        end
    end

    assign w_pop = (w_dec_action == DEC_LOAD);

    rv32_f_prefetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_prefetch_fifo (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_clear (redirect_i),
        .i_data  (w_push_entry),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count),
        .o_head  (w_head)
    );

    // PC, response-PC, credit and discard tracking; redirect takes priority.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_pc          <= RESET_PC;
            r_rsp_pc      <= RESET_PC;
            r_outstanding <= '0;
            r_discard     <= '0;
        end else if (redirect_i) begin
            // Nothing is issued this cycle; every request still in flight
            // (minus one answered right now, which is dropped) is stale.
            r_pc          <= w_target;
            r_rsp_pc      <= w_target;
            r_outstanding <= r_outstanding - OW'(imem_rvalid_i);
            r_discard     <= r_outstanding - OW'(imem_rvalid_i);
        end else begin
            if (w_accept) begin
                r_pc <= r_pc + PC_STEP;
            end
            if (w_push) begin
                r_rsp_pc <= r_rsp_pc + PC_STEP;
            end
            r_outstanding <= r_outstanding + OW'(w_accept) - OW'(imem_rvalid_i);
            if (imem_rvalid_i && (r_discard != '0)) begin
                r_discard <= r_discard - OW'(1);
            end
        end
    end

    // Fetch-to-decode pipeline register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_instr_d   <= NOP_INSTR;
            r_pc_d      <= '0;
            r_pc_next_d <= '0;
            r_valid_d   <= 1'b0;
        end else begin
            case (w_dec_action)
                DEC_LOAD: begin
                    r_instr_d   <= w_head.instr;
                    r_pc_d      <= w_head.pc;
                    r_pc_next_d <= w_head.pc + PC_STEP;
                    r_valid_d   <= 1'b1;
                end
                DEC_HOLD: begin
                    r_instr_d   <= r_instr_d;
                    r_pc_d      <= r_pc_d;
                    r_pc_next_d <= r_pc_next_d;
                    r_valid_d   <= r_valid_d;
                end
                default: begin
                    r_instr_d   <= NOP_INSTR;
                    r_pc_d      <= '0;
                    r_pc_next_d <= '0;
                    r_valid_d   <= 1'b0;
                end
            endcase
        end
    end

    assign instr_o   = r_instr_d;
    assign pc_o      = r_pc_d;
    assign pc_next_o = r_pc_next_d;
    assign valid_o   = r_valid_d;

    // Protocol sanity: responses only for issued requests, FIFO never overrun.
    always_ff @(posedge clk_i) begin
        if (rst_n_i) begin
            assert (!(imem_rvalid_i && (r_outstanding == '0)));
            assert (!(w_push && w_fifo_full && !w_pop));
        end
    end

endmodule

// File: tb/tb_rv32_fetch.sv
// Self-checking bench for rv32_fetch: a queue-based model of the fetch
// stream plus an in-order variable-latency instruction memory.
module tb_rv32_fetch;

    localparam int DEPTH = 2;
    localparam int MAXO  = 2;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] KEY = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst_n_i;
    logic        stall_d_i, flush_d_i, redirect_i;
    logic [31:0] pc_target_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ready_i, imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic [31:0] instr_o, pc_o, pc_next_o;
    logic        valid_o;

    always #5 clk = ~clk;

    rv32_fetch #(
        .RESET_PC        (32'h0000_0000),
        .FIFO_DEPTH      (DEPTH),
        .MAX_OUTSTANDING (MAXO)
    ) dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n_i),
        .stall_d_i     (stall_d_i),
        .flush_d_i     (flush_d_i),
        .redirect_i    (redirect_i),
        .pc_target_i   (pc_target_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_ready_i  (imem_ready_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .instr_o       (instr_o),
        .pc_o          (pc_o),
        .pc_next_o     (pc_next_o),
        .valid_o       (valid_o)
    );

    typedef struct { logic [31:0] addr; int due; } pend_t;
    typedef struct { logic [31:0] pc; logic [31:0] ins; } ent_t;

    pend_t pend[$];          // memory: accepted requests awaiting response
    ent_t  mq[$];            // model: fetched instructions awaiting decode
    logic [31:0] seen[$];    // PCs newly delivered to decode, in order

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_due = -1;

    // model state
    logic [31:0] m_pc, m_rsp, m_instr, m_pcd, m_pcn, exp_seq;
    logic        m_valid;
    int          m_out, m_disc;

    // stimulus knobs
    logic        stall, flush, redir, ready;
    logic [31:0] tgt;
    int          lat;
    logic        prev_stall;

    // last sampled DUT values, for directed checks
    logic        last_req, last_valid;
    logic [31:0] last_addr, last_instr, last_pc;

    logic        watch_acc, acc_seen;
    logic [31:0] first_acc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d actual=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_rsp = 32'h0; m_out = 0; m_disc = 0;
        mq.delete(); pend.delete(); last_due = -1;
        m_instr = NOP; m_pcd = 32'h0; m_pcn = 32'h0; m_valid = 1'b0;
        exp_seq = 32'h0; prev_stall = 1'b0;
    endtask

    // One clock cycle: drive at the falling edge, sample 1ns later, advance
    // the model across the next rising edge.
    task automatic step();
        logic        exp_req, acc, rv;
        logic [31:0] rd, acc_addr;
        int          d;
        ent_t        e;
        stall_d_i    = stall;
        flush_d_i    = flush;
        redirect_i   = redir;
        pc_target_i  = tgt;
        imem_ready_i = ready;
        rv = (pend.size() > 0) && (pend[0].due <= cyc);
        rd = rv ? (pend[0].addr ^ KEY) : $urandom();
        imem_rvalid_i = rv;
        imem_rdata_i  = rd;
        #1;
        exp_req = !redir && (m_disc == 0) && (m_out < MAXO) && (m_out + mq.size() < DEPTH);
        check("imem_req", imem_req_o, exp_req);
        if (exp_req) check("imem_addr", imem_addr_o, m_pc);
        check("instr", instr_o, m_instr);
        check("pc", pc_o, m_pcd);
        check("pc_next", pc_next_o, m_pcn);
        check("valid", valid_o, m_valid);
        // stream continuity: each new delivery is the next word, or the
        // latest redirect target
        if (!prev_stall && valid_o) begin
            check("seq_pc", pc_o, exp_seq);
            check("seq_instr", instr_o, pc_o ^ KEY);
            seen.push_back(pc_o);
            exp_seq = pc_o + 32'd4;
        end
        last_req = imem_req_o; last_addr = imem_addr_o;
        last_instr = instr_o; last_pc = pc_o; last_valid = valid_o;

        // decode register
        if (flush || (!stall && (redir || mq.size() == 0))) begin
            m_instr = NOP; m_pcd = 32'h0; m_pcn = 32'h0; m_valid = 1'b0;
        end else if (!stall) begin
            e = mq.pop_front();
            m_instr = e.ins; m_pcd = e.pc; m_pcn = e.pc + 32'd4; m_valid = 1'b1;
        end
        // fetch side
        acc = exp_req && ready;
        acc_addr = m_pc;
        if (redir) begin
            if (rv) m_out--;
            m_disc = m_out;
            mq.delete();
            m_pc = tgt & ~32'h3; m_rsp = m_pc; exp_seq = m_pc;
        end else begin
            if (acc) begin m_pc = m_pc + 32'd4; m_out++; end
            if (rv) begin
                m_out--;
                if (m_disc > 0) m_disc--;
                else begin mq.push_back('{pc: m_rsp, ins: rd}); m_rsp = m_rsp + 32'd4; end
            end
        end
        // memory
        if (rv) void'(pend.pop_front());
        if (acc) begin
            d = cyc + lat;
            if (d <= last_due) d = last_due + 1;
            pend.push_back('{addr: acc_addr, due: d});
            last_due = d;
            if (watch_acc && !acc_seen) begin acc_seen = 1'b1; first_acc = acc_addr; end
        end
        prev_stall = stall;
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    initial begin
        int   idx, n;
        ent_t head;
        rst_n_i = 1'b0;
        stall_d_i = 0; flush_d_i = 0; redirect_i = 0; pc_target_i = 0;
        imem_ready_i = 0; imem_rvalid_i = 0; imem_rdata_i = 0;
        stall = 0; flush = 0; redir = 0; ready = 1; tgt = 0; lat = 1;
        watch_acc = 0; acc_seen = 0; first_acc = 0;
        model_reset();

        // reset values
        repeat (3) @(negedge clk);
        #1;
        check("rst_instr", instr_o, 32'h0000_0013);
        check("rst_pc", pc_o, 32'h0);
        check("rst_pc_next", pc_next_o, 32'h0);
        check("rst_valid", valid_o, 1'b0);
        check("rst_req", imem_req_o, 1'b0);
        @(negedge clk);
        rst_n_i = 1'b1;

        // back-to-back streaming, 1-cycle latency
        ready = 1; lat = 1;
        step();
        check("first_req", last_req, 1'b1);
        check("first_addr", last_addr, 32'h0);
        repeat (12) step();
        if (seen.size() >= 3) begin
            check("stream_pc0", seen[0], 32'h0);
            check("stream_pc1", seen[1], 32'h4);
            check("stream_pc2", seen[2], 32'h8);
        end else check("stream_count", seen.size(), 3);

        // stall mid-stream: FIFO fills, request drops
        stall = 1;
        repeat (3) step();
        check("stall_req_drop", last_req, 1'b0);
        stall = 0;
        repeat (8) step();

        // redirect with two requests outstanding
        lat = 4;
        n = 0;
        while (m_out != 2 && n < 20) begin step(); n++; end
        check("reach_out2", m_out, 2);
        idx = seen.size();
        redir = 1; flush = 1; tgt = 32'h0000_0103;
        step();
        redir = 0; flush = 0;
        watch_acc = 1; acc_seen = 0;
        repeat (25) step();
        watch_acc = 0;
        check("redir_acc_seen", acc_seen, 1'b1);
        check("redir_first_addr", first_acc, 32'h0000_0100);
        if (seen.size() > idx) check("redir_first_pc", seen[idx], 32'h0000_0100);
        else check("redir_delivered", seen.size(), idx + 1);

        // redirect coinciding with the only outstanding response
        lat = 1;
        n = 0;
        while (!(m_out == 1 && pend.size() > 0 && pend[0].due <= cyc) && n < 20) begin step(); n++; end
        check("reach_rv_out1", m_out, 1);
        redir = 1; flush = 1; tgt = 32'h0000_0200;
        step();
        redir = 0; flush = 0;
        step();
        check("redir_rv_req", last_req, 1'b1);
        check("redir_rv_addr", last_addr, 32'h0000_0200);
        repeat (6) step();

        // flush without redirect: one bubble, head then delivered unchanged
        n = 0;
        while (mq.size() == 0 && n < 20) begin step(); n++; end
        check("fifo_nonempty", mq.size() > 0, 1'b1);
        head = mq[0];
        flush = 1;
        step();
        flush = 0;
        step();
        check("flush_instr", last_instr, 32'h0000_0013);
        check("flush_valid", last_valid, 1'b0);
        step();
        check("flush_head_pc", last_pc, head.pc);
        check("flush_head_instr", last_instr, head.ins);

        // ready low for 4 cycles, then long latency
        ready = 0;
        repeat (4) step();
        ready = 1; lat = 5;
        repeat (30) step();

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            ready = ($urandom_range(3) != 0);
            lat   = 1 + $urandom_range(4);
            stall = ($urandom_range(99) < 15);
            flush = ($urandom_range(99) < 10);
            redir = ($urandom_range(99) < 5);
            if (redir) begin
                tgt   = $urandom();
                flush = ($urandom_range(9) != 0);
                if (!flush) stall = 1'b0;
            end
            step();
        end
        stall = 0; flush = 0; redir = 0;

        // async reset in the middle of a burst
        ready = 1; lat = 2;
        repeat (10) step();
        imem_rvalid_i = 0;
        #3;
        rst_n_i = 1'b0;
        #1;
        check("arst_instr", instr_o, 32'h0000_0013);
        check("arst_pc", pc_o, 32'h0);
        check("arst_pc_next", pc_next_o, 32'h0);
        check("arst_valid", valid_o, 1'b0);
        check("arst_req", imem_req_o, 1'b0);
        model_reset();
        repeat (2) @(negedge clk);
        rst_n_i = 1'b1;
        idx = seen.size();
        lat = 1;
        repeat (10) step();
        if (seen.size() > idx) check("arst_first_pc", seen[idx], 32'h0);
        else check("arst_delivered", seen.size(), idx + 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
